// File: rtl/upload_out_req_fifo.sv
// Packet-aware store-and-forward flit FIFO between the upload flit FSM and the ring
// local-out arbiter; flits are offered only once a whole packet (tail) is buffered.
module upload_out_req_fifo #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int FLIT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_flit_out,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic [1:0]        ctrl_in,
  output logic              out_req_fifo_rdy,
  output logic [FLIT_W-1:0] flit_out,
  output logic [1:0]        ctrl_out,
  output logic              flit_valid,
  input  logic              ring_grant,
  output logic [PTR_W:0]    pkt_cnt,
  output logic [PTR_W:0]    flit_cnt,
  output logic              proto_err
);

  localparam logic [1:0]       CTRL_NONE = 2'b00;
  localparam logic [1:0]       CTRL_HEAD = 2'b01;
  localparam logic [1:0]       CTRL_TAIL = 2'b11;
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);

  logic [FLIT_W+1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    flit_cnt_r;
  logic [PTR_W:0]    pkt_cnt_r;
  logic              in_pkt_r;
  logic              proto_err_r;

  logic              rdy_s;
  logic              push_req_s;
  logic              orphan_s;
  logic              wr_en_s;
  logic              pop_s;
  logic              valid_s;
  logic              dup_head_s;
  logic [FLIT_W+1:0] head_entry_s;

  assign rdy_s = (flit_cnt_r < FULL_CNT);

  // Push/pop qualification and head-of-FIFO read
  always_comb begin
    push_req_s   = en_flit_out && (ctrl_in != CTRL_NONE) && rdy_s;
    // body/tail outside a packet has nothing to attach to and is discarded
    orphan_s     = push_req_s && ctrl_in[1] && !in_pkt_r;
    wr_en_s      = push_req_s && !orphan_s;
    dup_head_s   = wr_en_s && (ctrl_in == CTRL_HEAD) && in_pkt_r;
    valid_s      = (flit_cnt_r != {(PTR_W+1){1'b0}}) && (pkt_cnt_r != {(PTR_W+1){1'b0}});
    pop_s        = valid_s && ring_grant;
    head_entry_s = (flit_cnt_r != {(PTR_W+1){1'b0}}) ? mem_r[rd_ptr_r] : {(FLIT_W+2){1'b0}};
  end

  // Flit storage (no reset: entries are only observed while counted)
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {ctrl_in, flit_in};
    end
  end

  // Pointers, occupancy and packet counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      flit_cnt_r <= {(PTR_W+1){1'b0}};
      pkt_cnt_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_IDX) ? {PTR_W{1'b0}} : wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_IDX) ? {PTR_W{1'b0}} : rd_ptr_r + 1'b1;
      end
      case ({wr_en_s, pop_s})
        2'b10:   flit_cnt_r <= flit_cnt_r + 1'b1;
        2'b01:   flit_cnt_r <= flit_cnt_r - 1'b1;
        default: flit_cnt_r <= flit_cnt_r;
      endcase
      case ({wr_en_s && (ctrl_in == CTRL_TAIL), pop_s && (head_entry_s[FLIT_W+1:FLIT_W] == CTRL_TAIL)})
        2'b10:   pkt_cnt_r <= pkt_cnt_r + 1'b1;
        2'b01:   pkt_cnt_r <= pkt_cnt_r - 1'b1;
        default: pkt_cnt_r <= pkt_cnt_r;
      endcase
    end
  end

  // Packet framing state and sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt_r    <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        case (ctrl_in)
          CTRL_HEAD: in_pkt_r <= 1'b1;
          CTRL_TAIL: in_pkt_r <= 1'b0;
          default:   in_pkt_r <= in_pkt_r;
        endcase
      end
      if (orphan_s || dup_head_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign out_req_fifo_rdy = rdy_s;
  assign flit_out         = head_entry_s[FLIT_W-1:0];
  assign ctrl_out         = head_entry_s[FLIT_W+1:FLIT_W];
  assign flit_valid       = valid_s;
  assign pkt_cnt          = pkt_cnt_r;
  assign flit_cnt         = flit_cnt_r;
  assign proto_err        = proto_err_r;

endmodule

// File: tb/tb_upload_out_req_fifo.sv
// Directed bench for upload_out_req_fifo: a vector table for the basic packet flow
// and protocol errors, plus hand sequences for fill/wrap and async mid-packet reset.
module tb_upload_out_req_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_flit_out = 1'b0;
  logic [15:0] flit_in = 16'h0000;
  logic [1:0]  ctrl_in = 2'b00;
  logic        ring_grant = 1'b0;
  logic        out_req_fifo_rdy;
  logic [15:0] flit_out;
  logic [1:0]  ctrl_out;
  logic        flit_valid;
  logic [4:0]  pkt_cnt;
  logic [4:0]  flit_cnt;
  logic        proto_err;

  int passed = 0;
  int total  = 0;

  upload_out_req_fifo #(.DEPTH(16), .PTR_W(4), .FLIT_W(16)) dut (
    .clk(clk), .rst(rst), .en_flit_out(en_flit_out), .flit_in(flit_in),
    .ctrl_in(ctrl_in), .out_req_fifo_rdy(out_req_fifo_rdy), .flit_out(flit_out),
    .ctrl_out(ctrl_out), .flit_valid(flit_valid), .ring_grant(ring_grant),
    .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] flit;
    logic [1:0]  ctrl;
    logic        grant;
    logic        rdy;
    logic [15:0] fout;
    logic [1:0]  cout;
    logic        valid;
    logic [4:0]  pkt;
    logic [4:0]  fc;
    logic        err;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic [15:0] fout,
                         input logic [1:0] cout, input logic valid, input logic [4:0] pkt,
                         input logic [4:0] fc, input logic err);
    chk({tag, ".rdy"},   32'(out_req_fifo_rdy), 32'(rdy));
    chk({tag, ".flit"},  32'(flit_out),         32'(fout));
    chk({tag, ".ctrl"},  32'(ctrl_out),         32'(cout));
    chk({tag, ".valid"}, 32'(flit_valid),       32'(valid));
    chk({tag, ".pkt"},   32'(pkt_cnt),          32'(pkt));
    chk({tag, ".fcnt"},  32'(flit_cnt),         32'(fc));
    chk({tag, ".err"},   32'(proto_err),        32'(err));
  endtask

  task automatic step(input logic en, input logic [15:0] f, input logic [1:0] c, input logic g);
    en_flit_out = en;
    flit_in     = f;
    ctrl_in     = c;
    ring_grant  = g;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge
  task automatic pulse_reset(input string tag);
    en_flit_out = 1'b0;
    ring_grant  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all(tag, 1'b1, 16'h0000, 2'b00, 1'b0, 5'd0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //           en  flit      ctrl   g     rdy   fout      cout   v     pkt   fc    err
    vecs[0]  = '{1'b1, 16'h1001, 2'b01, 1'b0, 1'b1, 16'h1001, 2'b01, 1'b0, 5'd0, 5'd1, 1'b0};
    vecs[1]  = '{1'b1, 16'h2002, 2'b10, 1'b0, 1'b1, 16'h1001, 2'b01, 1'b0, 5'd0, 5'd2, 1'b0};
    vecs[2]  = '{1'b1, 16'h2003, 2'b10, 1'b0, 1'b1, 16'h1001, 2'b01, 1'b0, 5'd0, 5'd3, 1'b0};
    vecs[3]  = '{1'b1, 16'h3004, 2'b11, 1'b0, 1'b1, 16'h1001, 2'b01, 1'b1, 5'd1, 5'd4, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h1001, 2'b01, 1'b1, 5'd1, 5'd4, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h2002, 2'b10, 1'b1, 5'd1, 5'd3, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h2003, 2'b10, 1'b1, 5'd1, 5'd2, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h3004, 2'b11, 1'b1, 5'd1, 5'd1, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h0000, 2'b00, 1'b0, 5'd0, 5'd0, 1'b0};
    // ctrl 00 is not a flit; grant with nothing valid is ignored
    vecs[9]  = '{1'b1, 16'hDEAD, 2'b00, 1'b1, 1'b1, 16'h0000, 2'b00, 1'b0, 5'd0, 5'd0, 1'b0};
    // orphan body and tail are dropped, error is sticky
    vecs[10] = '{1'b1, 16'h0BAD, 2'b10, 1'b0, 1'b1, 16'h0000, 2'b00, 1'b0, 5'd0, 5'd0, 1'b1};
    vecs[11] = '{1'b1, 16'h0BAE, 2'b11, 1'b0, 1'b1, 16'h0000, 2'b00, 1'b0, 5'd0, 5'd0, 1'b1};
    // packet A stored, then B's tail pushed while A's tail pops
    vecs[12] = '{1'b1, 16'h1111, 2'b01, 1'b0, 1'b1, 16'h1111, 2'b01, 1'b0, 5'd0, 5'd1, 1'b1};
    vecs[13] = '{1'b1, 16'h1112, 2'b11, 1'b0, 1'b1, 16'h1111, 2'b01, 1'b1, 5'd1, 5'd2, 1'b1};
    vecs[14] = '{1'b1, 16'h2221, 2'b01, 1'b1, 1'b1, 16'h1112, 2'b11, 1'b1, 5'd1, 5'd2, 1'b1};
    vecs[15] = '{1'b1, 16'h2222, 2'b11, 1'b1, 1'b1, 16'h2221, 2'b01, 1'b1, 5'd1, 5'd2, 1'b1};
    vecs[16] = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h2222, 2'b11, 1'b1, 5'd1, 5'd1, 1'b1};
    vecs[17] = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h0000, 2'b00, 1'b0, 5'd0, 5'd0, 1'b1};

    #3;
    chk_all("reset_hold", 1'b1, 16'h0000, 2'b00, 1'b0, 5'd0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("reset_rel", 1'b1, 16'h0000, 2'b00, 1'b0, 5'd0, 5'd0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].en, vecs[i].flit, vecs[i].ctrl, vecs[i].grant);
      chk_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].fout, vecs[i].cout,
              vecs[i].valid, vecs[i].pkt, vecs[i].fc, vecs[i].err);
    end

    // Fill all 16 entries with one packet
    pulse_reset("rst_before_fill");
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'h4000 + 16'(i), (i == 0) ? 2'b01 : ((i == 15) ? 2'b11 : 2'b10), 1'b0);
    end
    chk_all("full", 1'b0, 16'h4000, 2'b01, 1'b1, 5'd1, 5'd16, 1'b0);
    step(1'b1, 16'hFFFF, 2'b10, 1'b0);
    chk_all("push_when_full", 1'b0, 16'h4000, 2'b01, 1'b1, 5'd1, 5'd16, 1'b0);
    // rdy comes from the registered count, so the push offered with the pop is held off a cycle
    step(1'b1, 16'h5000, 2'b01, 1'b1);
    chk_all("pop_at_full", 1'b1, 16'h4001, 2'b10, 1'b1, 5'd1, 5'd15, 1'b0);
    step(1'b1, 16'h5000, 2'b01, 1'b0);
    chk_all("refill", 1'b0, 16'h4001, 2'b10, 1'b1, 5'd1, 5'd16, 1'b0);
    for (int j = 1; j < 15; j++) begin
      step(1'b0, 16'h0000, 2'b00, 1'b1);
      chk($sformatf("drain%0d.flit", j), 32'(flit_out), 32'(16'h4001 + 16'(j)));
      chk($sformatf("drain%0d.ctrl", j), 32'(ctrl_out), (j == 14) ? 32'd3 : 32'd2);
    end
    // the wrapped head sits in entry 0 but its packet is incomplete
    step(1'b0, 16'h0000, 2'b00, 1'b1);
    chk_all("wrapped_head", 1'b1, 16'h5000, 2'b01, 1'b0, 5'd0, 5'd1, 1'b0);
    step(1'b0, 16'h0000, 2'b00, 1'b1);
    chk_all("no_pop_partial", 1'b1, 16'h5000, 2'b01, 1'b0, 5'd0, 5'd1, 1'b0);

    // Mid-packet asynchronous reset discards the partial packet
    pulse_reset("rst_before_mid");
    step(1'b1, 16'h6001, 2'b01, 1'b0);
    step(1'b1, 16'h6002, 2'b10, 1'b0);
    chk_all("two_stored", 1'b1, 16'h6001, 2'b01, 1'b0, 5'd0, 5'd2, 1'b0);
    pulse_reset("rst_mid_pkt");
    step(1'b1, 16'h7001, 2'b01, 1'b0);
    chk_all("head_after_rst", 1'b1, 16'h7001, 2'b01, 1'b0, 5'd0, 5'd1, 1'b0);
    step(1'b1, 16'h7002, 2'b01, 1'b0);
    chk_all("dup_head", 1'b1, 16'h7001, 2'b01, 1'b0, 5'd0, 5'd2, 1'b1);
    step(1'b1, 16'h7003, 2'b11, 1'b0);
    chk_all("dup_head_tail", 1'b1, 16'h7001, 2'b01, 1'b1, 5'd1, 5'd3, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
